// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI scheduler.
// Used by spi_scheduler; the optional SPI_SCHED_CFG_CACHE_EN feature lives in the top.
package spi_pkg;

  localparam int BYTE_W  = 8;
  localparam int RATIO_W = 8;
  localparam int MODE_W  = 2;
  localparam int CFG_W   = RATIO_W + MODE_W + 1;

  // Ratios below this value cannot produce a valid SCLK and are promoted to it
  localparam logic [RATIO_W-1:0] MIN_RATIO = 8'd2;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ARB        = 4'd1,
    ST_CFG_ISSUE  = 4'd2,
    ST_CFG_WAIT   = 4'd3,
    ST_CS_SETUP   = 4'd4,
    ST_BYTE_ISSUE = 4'd5,
    ST_BYTE_WAIT  = 4'd6,
    ST_BYTE_NEXT  = 4'd7,
    ST_CS_HOLD    = 4'd8
  } spi_state_t;

  typedef struct packed {
    logic [RATIO_W-1:0] ratio;
    logic [MODE_W-1:0]  mode;
    logic               valid;
  } spi_cfg_t;

  // Build a controller configuration word, clamping unusable ratios
  function automatic spi_cfg_t make_cfg(input logic [RATIO_W-1:0] ratio,
                                        input logic [MODE_W-1:0]  mode);
    spi_cfg_t c;
    c.ratio = (ratio < MIN_RATIO) ? MIN_RATIO : ratio;
    c.mode  = mode;
    c.valid = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after the
// priority pointer. On i_advance the pointer moves to the one after the grantee.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_next_ptr;
  logic           w_found;

  // Scan requesters starting at the pointer, first hit wins
  always_comb begin
    o_grant    = '0;
    w_next_ptr = r_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = IDW'((int'(r_ptr) + off) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_next_ptr     = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  // Priority pointer, moved past the grantee when a grant is taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ptr <= '0;
    else if (i_advance) r_ptr <= w_next_ptr;
  end

endmodule

// File: rtl/spi_scheduler.sv
// Shares one SPI controller among NUM_REQ requesters: round-robin burst
// arbitration, controller configuration, chip-select framing with CS_GAP
// guard cycles, and per-byte command/response handshaking.
// Optional feature macro: SPI_SCHED_CFG_CACHE_EN skips reconfiguration when the
// grantee's {ratio, mode} matches the last configuration issued.
module spi_scheduler
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]  i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_last,
  input  logic [MODE_W*NUM_REQ-1:0]  i_req_mode,
  input  logic [RATIO_W*NUM_REQ-1:0] i_req_ratio,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [BYTE_W-1:0]          o_rsp_data,
  output logic                       o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic                       o_rsp_last,
  output logic [NUM_REQ-1:0]         o_cs_n,
  output logic [CFG_W-1:0]           o_spi_config,
  output logic [BYTE_W-1:0]          o_spi_tx,
  output logic                       o_spi_tx_valid,
  input  logic                       i_spi_ready,
  input  logic [BYTE_W-1:0]          i_spi_rx
);

  localparam int IDW      = $clog2(NUM_REQ);
  localparam int CNT_W    = 16;
  localparam int GAP_LAST = (CS_GAP > 0) ? CS_GAP - 1 : 0;

  spi_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt_oh;
  logic [IDW-1:0]      r_gnt_idx;
  spi_cfg_t            r_cfg;
  logic [BYTE_W-1:0]   r_tx;
  logic                r_last;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [BYTE_W-1:0]   r_rsp_data;
  logic                r_rsp_valid;
  logic [IDW-1:0]      r_rsp_id;
  logic                r_rsp_last;
  logic [CNT_W-1:0]    r_cnt;

  logic [BYTE_W-1:0]   w_data  [NUM_REQ];
  logic [RATIO_W-1:0]  w_ratio [NUM_REQ];
  logic [MODE_W-1:0]   w_mode  [NUM_REQ];
  logic [NUM_REQ-1:0]  w_grant;
  logic [IDW-1:0]      w_arb_idx;
  spi_cfg_t            w_arb_cfg;
  logic                w_cache_hit;
  logic                w_advance;
  logic                w_cs_active;
  logic                w_gap_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_data[g]  = i_req_data[BYTE_W*g +: BYTE_W];
    assign w_ratio[g] = i_req_ratio[RATIO_W*g +: RATIO_W];
    assign w_mode[g]  = i_req_mode[MODE_W*g +: MODE_W];
  end

  // The pointer moves when ARB takes a grant, so the next ARB favours grantee+1
  assign w_advance = (r_state == ST_ARB);

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req_valid),
    .i_advance (w_advance),
    .o_grant   (w_grant)
  );

  // One-hot grant to index
  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant[i]) w_arb_idx = IDW'(i);
  end

  assign w_arb_cfg  = make_cfg(w_ratio[w_arb_idx], w_mode[w_arb_idx]);
  assign w_gap_done = (r_cnt == CNT_W'(GAP_LAST));

`ifdef SPI_SCHED_CFG_CACHE_EN
  spi_cfg_t r_cache_cfg;
  logic     r_cache_vld;

  assign w_cache_hit = r_cache_vld && (r_cache_cfg == w_arb_cfg);

  // Remember the configuration the controller accepted last
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cache_cfg <= '0;
      r_cache_vld <= 1'b0;
    end else if (r_state == ST_CFG_WAIT && i_spi_ready) begin
      r_cache_cfg <= r_cfg;
      r_cache_vld <= 1'b1;
    end
  end
`else
  assign w_cache_hit = 1'b0;
`endif

  // Burst sequencer: arbitration, configuration, CS framing and byte handshakes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_oh    <= '0;
      r_gnt_idx   <= '0;
      r_cfg       <= '0;
      r_tx        <= '0;
      r_last      <= 1'b0;
      r_req_ready <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_last  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (|i_req_valid && i_spi_ready) r_state <= ST_ARB;
        ST_ARB:
          if (|w_grant) begin
            r_gnt_oh  <= w_grant;
            r_gnt_idx <= w_arb_idx;
            r_cfg     <= w_arb_cfg;
            r_cnt     <= '0;
            r_state   <= w_cache_hit ? ST_CS_SETUP : ST_CFG_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        ST_CFG_ISSUE:
          if (!i_spi_ready) r_state <= ST_CFG_WAIT;
        ST_CFG_WAIT:
          if (i_spi_ready) begin
            r_cnt   <= '0;
            r_state <= ST_CS_SETUP;
          end
        ST_CS_SETUP:
          if (w_gap_done) begin
            r_tx        <= w_data[r_gnt_idx];
            r_last      <= i_req_last[r_gnt_idx];
            r_req_ready <= r_gnt_oh;
            r_state     <= ST_BYTE_ISSUE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        ST_BYTE_ISSUE:
          if (!i_spi_ready) r_state <= ST_BYTE_WAIT;
        ST_BYTE_WAIT:
          if (i_spi_ready) begin
            r_rsp_data  <= i_spi_rx;
            r_rsp_id    <= r_gnt_idx;
            r_rsp_last  <= r_last;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= r_last ? ST_CS_HOLD : ST_BYTE_NEXT;
          end
        ST_BYTE_NEXT:
          if (i_req_valid[r_gnt_idx]) begin
            r_tx        <= w_data[r_gnt_idx];
            r_last      <= i_req_last[r_gnt_idx];
            r_req_ready <= r_gnt_oh;
            r_state     <= ST_BYTE_ISSUE;
          end
        ST_CS_HOLD:
          if (w_gap_done) r_state <= ST_IDLE;
          else            r_cnt   <= r_cnt + 1'b1;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  // Chip select follows the state register directly so reset releases it at once
  always_comb begin
    w_cs_active = 1'b0;
    case (r_state)
      ST_CS_SETUP, ST_BYTE_ISSUE, ST_BYTE_WAIT, ST_BYTE_NEXT, ST_CS_HOLD:
        w_cs_active = 1'b1;
      default:
        w_cs_active = 1'b0;
    endcase
  end

  assign o_cs_n         = w_cs_active ? ~r_gnt_oh : '1;
  assign o_spi_config   = (r_state == ST_CFG_ISSUE) ? r_cfg : spi_cfg_t'('0);
  assign o_spi_tx       = r_tx;
  assign o_spi_tx_valid = (r_state == ST_BYTE_ISSUE);
  assign o_req_ready    = r_req_ready;
  assign o_rsp_data     = r_rsp_data;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_id       = r_rsp_id;
  assign o_rsp_last     = r_rsp_last;

endmodule

// File: doc/spi_scheduler.md
SPI_SCHEDULER -- requirements
Module: spi_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one spi_controller (range 2..4).
REQ-002 SHALL have parameter CS_GAP, default 2, i_clk cycles between CS_n falling and first byte, and between last byte and CS_n rising.
REQ-003 SHALL have ports (clock and reset first); one clock; reset is asynchronous and active-low:
  i_clk  in  1  system clock
  i_rst_n  in  1  asynchronous active-low reset
  i_req_valid  in  NUM_REQ  per-requester byte valid
  i_req_data  in  8*NUM_REQ  per-requester TX byte
  i_req_last  in  NUM_REQ  byte is last of burst
  i_req_mode  in  2*NUM_REQ  per-requester SPI mode
  i_req_ratio  in  8*NUM_REQ  per-requester clock ratio
  o_req_ready  out  NUM_REQ  one-cycle byte-accept pulse
  o_rsp_data  out  8  received byte
  o_rsp_valid  out  1  one-cycle RX pulse
  o_rsp_id  out  $clog2(NUM_REQ)  requester owning o_rsp_data
  o_rsp_last  out  1  o_rsp_data closes burst
  o_cs_n  out  NUM_REQ  active-low chip selects
  o_spi_config  out  11  {ratio[7:0], mode[1:0], cfg_valid} to controller
  o_spi_tx  out  8  TX byte to controller
  o_spi_tx_valid  out  1  TX command to controller
  i_spi_ready  in  1  controller idle
  i_spi_rx  in  8  controller RX byte

Function
REQ-004 SHALL implement states IDLE, ARB, CFG_ISSUE, CFG_WAIT, CS_SETUP, BYTE_ISSUE, BYTE_WAIT, BYTE_NEXT, CS_HOLD.
REQ-005 IDLE -> ARB when any i_req_valid bit high and i_spi_ready high.
REQ-006 ARB SHALL grant round-robin: after reset priority starts at requester 0; after burst to k, k+1 mod NUM_REQ has highest priority; grant held until burst ends.
REQ-007 Controller handshake: command strobe held high until first cycle i_spi_ready is low, then driven low; command complete on first cycle i_spi_ready returns high.
REQ-008 CFG_ISSUE SHALL drive o_spi_config = {ratio, mode, 1'b1} of grantee; ratio values 0 or 1 SHALL be replaced by 2; o_spi_config SHALL be 0 outside CFG_ISSUE.
REQ-009 CFG_WAIT -> CS_SETUP on completion; CS_SETUP drives grantee CS_n low, waits CS_GAP cycles, then -> BYTE_ISSUE.
REQ-010 On BYTE_ISSUE entry, scheduler SHALL latch grantee data/last, pulse grantee o_req_ready for exactly one cycle, and drive o_spi_tx/o_spi_tx_valid per REQ-007.
REQ-011 On BYTE_WAIT completion, SHALL drive o_rsp_data = i_spi_rx, o_rsp_id = grantee, o_rsp_last = latched last, o_rsp_valid high for one cycle.
REQ-012 After non-last byte -> BYTE_NEXT; BYTE_NEXT -> BYTE_ISSUE when grantee valid high; CS_n stays low indefinitely while grantee valid low.
REQ-013 After last byte -> CS_HOLD for CS_GAP cycles, CS_n rises, -> IDLE; back-to-back bursts SHALL see CS_n high for at least one cycle.
REQ-014 At most one o_cs_n bit low at any time; valid bits of non-granted requesters SHALL be ignored.

Reset
REQ-015 While i_rst_n low: state IDLE, o_cs_n all ones, o_req_ready/o_rsp_valid/o_spi_tx_valid/o_rsp_last 0, o_spi_config/o_spi_tx/o_rsp_data/o_rsp_id 0, priority pointer 0, config cache invalid.
REQ-016 Reset mid-burst SHALL deassert CS_n asynchronously; no o_rsp_valid for the aborted byte.

Configuration
REQ-017 With SPI_SCHED_CFG_CACHE_EN defined, ARB SHALL skip CFG_ISSUE/CFG_WAIT when grantee {ratio, mode} equals last issued config and cache valid; without it, every burst SHALL reconfigure.

Structure
REQ-018 Package spi_pkg SHALL hold state enum, spi_cfg_t packed {ratio[7:0], mode[1:0], valid}, and width constants.
REQ-019 Round-robin grant SHALL live in sub-module spi_rr_arbiter (request vector, advance strobe, one-hot grant).

Verification
REQ-020 Single burst: req0 mode 0 ratio 2, bytes 0xA5,0x3C(last), loopback -> rsp 0xA5 then 0x3C id 0, last on second, CS_n[0] low throughout, two o_req_ready pulses.
REQ-021 Contention: req0 and req1 both valid 1-byte bursts at same cycle -> req0 served first, then req1; second ARB starts with req1 priority.
REQ-022 Ratio clamp: req1 ratio 0 mode 1 -> o_spi_config = {8'd2, 2'd1, 1'b1}.
REQ-023 Stall: req0 drops valid after byte 0x11 (not last) for 20 cycles -> CS_n[0] held low, no controller command, resumes on valid.
REQ-024 Cache: two identical-config bursts from req0 -> with SPI_SCHED_CFG_CACHE_EN one config command, without it two.
REQ-025 Reset mid BYTE_WAIT -> o_cs_n all ones same cycle, no o_rsp_valid, fresh burst after release completes correctly.
